// File: rtl/solar_pkg.sv
`default_nettype none
// ============================================================================
// Package    : solar_pkg
// Description: Shared types and default constants for the solar tracker
//              sweep logic and servo driver.
// Revision   : 1.0 - initial release
// ============================================================================
package solar_pkg;

   // Operating phase of the sweep/peak tracker
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SWEEP  = 2'd1,
      RETURN = 2'd2
   } phase_t;

   // Servo steps per full sweep and clock cycles per servo step
   localparam int SWEEP_STEPS_DEF = 180;
   localparam int STEP_DIV_DEF    = 100000;

endpackage
`default_nettype wire

// File: rtl/step_tick.sv
`default_nettype none
// ============================================================================
// Module     : step_tick
// Description: Servo step prescaler. Counts 0..STEP_DIV-1 while enabled and
//              emits a one-cycle tick on the terminal count. A low enable or
//              a high clear returns the count to zero.
// Revision   : 1.0 - initial release
// ============================================================================
module step_tick #(
   parameter int STEP_DIV = 100000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   input  logic clr,
   output logic tick
);

   localparam int             CNT_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
   localparam logic [CNT_W-1:0] TERM = CNT_W'(STEP_DIV - 1);

   logic [CNT_W-1:0] div_cnt;

   // Free-running divider, held at zero while disabled or cleared
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_cnt <= '0;
      end else if (clr || !en) begin
         div_cnt <= '0;
      end else if (div_cnt == TERM) begin
         div_cnt <= '0;
      end else begin
         div_cnt <= div_cnt + CNT_W'(1);
      end
   end

   // A clear in the same cycle suppresses the tick so no stale step leaks out
   assign tick = en && !clr && (div_cnt == TERM);

endmodule
`default_nettype wire

// File: rtl/sweep_max_tracker.sv
`default_nettype none
// ============================================================================
// Module     : sweep_max_tracker
// Description: Counts servo steps during a horizontal/vertical sweep, records
//              the step index of peak irradiance, then counts back to it.
//              Produces the sweep-limit flags polled by the calibration FSM.
// Revision   : 1.0 - initial release
// ============================================================================
module sweep_max_tracker
   import solar_pkg::*;
#(
   parameter int SWEEP_STEPS = SWEEP_STEPS_DEF,
   parameter int STEP_DIV    = STEP_DIV_DEF,
   parameter int ADC_W       = 12,
   parameter int POS_W       = $clog2(SWEEP_STEPS + 1)
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             HS,
   input  logic             VS,
   input  logic             MC,
   input  logic             CNT_RST,
   input  logic [ADC_W-1:0] ADC_DATA,
   input  logic             ADC_VALID,
   output logic             CNT_L,
   output logic             CNT_D,
   output logic             CNT_RU,
   output logic [POS_W-1:0] MAX_POS,
   output logic [ADC_W-1:0] MAX_VAL
);

   localparam logic [POS_W-1:0] POS_END = POS_W'(SWEEP_STEPS);

   phase_t           phase;
   logic             hs_d;
   logic             vs_d;
   logic [POS_W-1:0] pos;
   logic [POS_W-1:0] max_pos;
   logic [ADC_W-1:0] max_val;
   logic             sweep_start;
   logic             tick;
   logic             tick_en;
   logic             tick_clr;

   // A new sweep starts on a rising edge of HS or VS, but not while the other
   // enable is already held (HS and VS together must not re-clear state)
   always_comb begin
      sweep_start = ((HS & ~hs_d) | (VS & ~vs_d)) & ~((HS & hs_d) | (VS & vs_d));
   end

   // One-cycle-delayed copies of the sweep enables for edge detection
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         hs_d <= 1'b0;
         vs_d <= 1'b0;
      end else begin
         hs_d <= HS;
         vs_d <= VS;
      end
   end

   assign tick_en  = (phase != IDLE);
   assign tick_clr = CNT_RST | sweep_start;

   step_tick #(
      .STEP_DIV (STEP_DIV)
   ) u_step_tick (
      .clk   (CLK),
      .rst_n (RST),
      .en    (tick_en),
      .clr   (tick_clr),
      .tick  (tick)
   );

   // Phase sequencing plus position/peak bookkeeping; CNT_RST beats a sweep
   // start, which beats tick and sample updates
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         phase   <= IDLE;
         pos     <= '0;
         max_pos <= '0;
         max_val <= '0;
      end else begin
         if (CNT_RST) begin
            phase <= IDLE;
         end else if (HS || VS) begin
            phase <= SWEEP;
         end else if (MC) begin
            phase <= RETURN;
         end else begin
            phase <= IDLE;
         end

         if (CNT_RST || sweep_start) begin
            pos     <= '0;
            max_pos <= '0;
            max_val <= '0;
         end else begin
            case (phase)
               SWEEP: begin
                  // Strict compare keeps the earliest position on ties; the
                  // captured position is the one before this cycle's step
                  if (ADC_VALID && (ADC_DATA > max_val)) begin
                     max_val <= ADC_DATA;
                     max_pos <= pos;
                  end
                  if (tick && (pos != POS_END)) begin
                     pos <= pos + POS_W'(1);
                  end
               end
               RETURN: begin
                  if (tick && (pos > max_pos)) begin
                     pos <= pos - POS_W'(1);
                  end
               end
               default: begin
               end
            endcase
         end
      end
   end

   // Flags decode from registers only so the FSM sees no loop through HS/VS/MC
   assign CNT_L   = (pos != POS_END);
   assign CNT_D   = (pos != POS_END);
   assign CNT_RU  = (pos > max_pos);
   assign MAX_POS = max_pos;
   assign MAX_VAL = max_val;

endmodule
`default_nettype wire
